// File: rtl/handshake_arbiter.sv
// -----------------------------------------------------------------------------
// handshake_arbiter
//
// Round-robin arbiter that shares one valid/ready receive port between up to
// NUM_MASTERS requesting masters. One master owns the slave port at a time.
// It keeps the port for at most MAX_BURST beats, or until it drops its valid.
// After every release the bus spends exactly one cycle in IDLE, and the search
// for the next owner starts at the master after the one that just released.
//
// Ports
//   sys_clk     in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   m_vaild     in   [NUM_MASTERS]            per-master valid
//   m_data      in   [NUM_MASTERS*DATA_WIDTH] master i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_ready     out  [NUM_MASTERS]            per-master ready (only the owner sees s_ready)
//   s_vaild     out                           valid toward the slave
//   s_data      out  [DATA_WIDTH]             payload toward the slave (0 when idle)
//   s_ready     in                            slave ready
//   grant       out  [NUM_MASTERS]            one-hot current owner, 0 when idle
//   busy        out                           high while a master owns the bus
//   xfer_count  out  [16]                     completed slave-side beats, wraps
// -----------------------------------------------------------------------------
module handshake_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_BURST   = 4
) (
    input  logic                              sys_clk,
    input  logic                              reset_n,
    input  logic [NUM_MASTERS-1:0]            m_vaild,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data,
    output logic [NUM_MASTERS-1:0]            m_ready,
    output logic                              s_vaild,
    output logic [DATA_WIDTH-1:0]             s_data,
    input  logic                              s_ready,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic                              busy,
    output logic [15:0]                       xfer_count
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MASTERS - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [15:0]        xfer_count_q, xfer_count_d;

    logic                  in_grant;
    logic                  owner_vaild;
    logic                  beat;
    logic [IDX_W-1:0]      owner_next_ptr;
    logic                  req_found;
    logic [IDX_W-1:0]      req_idx;
    logic [DATA_WIDTH-1:0] m_data_arr [NUM_MASTERS];

    // Per-master views: payload slices, and ready/grant decoded from the
    // registered owner so neither output depends on the request inputs.
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
        assign m_data_arr[gi] = m_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign m_ready[gi]    = in_grant && (owner_q == IDX_W'(gi)) && s_ready;
        assign grant[gi]      = in_grant && (owner_q == IDX_W'(gi));
    end

    assign in_grant    = (state_q == ST_GRANT);
    assign owner_vaild = m_vaild[owner_q];
    assign beat        = in_grant && owner_vaild && s_ready;

    assign s_vaild    = in_grant && owner_vaild;
    assign s_data     = in_grant ? m_data_arr[owner_q] : '0;
    assign busy       = in_grant;
    assign xfer_count = xfer_count_q;

    assign owner_next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

    // Round-robin search: walk offsets from the far end down to 0 so the
    // requester closest to (or at) rr_ptr is the one left in req_idx.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        req_found = 1'b0;
        req_idx   = rr_ptr_q;
        cand      = 0;
        cand_idx  = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            cand_idx = IDX_W'(cand);
            if (m_vaild[cand_idx]) begin
                req_found = 1'b1;
                req_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        xfer_count_d = xfer_count_q;

        if (beat) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_found) begin
                    state_d    = ST_GRANT;
                    owner_d    = req_idx;
                    beat_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (!owner_vaild) begin
                    // Owner withdrew: release without a beat on this edge.
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_next_ptr;
                end else if (beat) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = ST_IDLE;
                        rr_ptr_d   = owner_next_ptr;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
                // Slave stall: hold everything, no timeout.
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            xfer_count_q <= xfer_count_d;
        end
    end

endmodule

// File: tb/tb_handshake_arbiter.sv
// -----------------------------------------------------------------------------
// tb_handshake_arbiter
//
// Bench for handshake_arbiter (4 masters, 8-bit data, bursts of 4). Each master
// is modelled as a source that sends base[i] + n for its n-th beat until it has
// sent limit[i] beats. The expected slave-side beats {grant, s_data} are queued
// when a scenario is set up and popped as beats appear. A second instance with
// 2 masters and bursts of 16 runs free in the background to reach the 16-bit
// transfer counter wrap.
// -----------------------------------------------------------------------------
module tb_handshake_arbiter;

    localparam int NM = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic                 sys_clk = 1'b0;
    logic                 reset_n;
    logic [NM-1:0]        m_vaild;
    logic [NM*DW-1:0]     m_data;
    logic [NM-1:0]        m_ready;
    logic                 s_vaild;
    logic [DW-1:0]        s_data;
    logic                 s_ready;
    logic [NM-1:0]        grant;
    logic                 busy;
    logic [15:0]          xfer_count;

    // background wrap instance
    logic                 w_rst_n;
    logic [1:0]           w_m_ready;
    logic                 w_s_vaild;
    logic [7:0]           w_s_data;
    logic [1:0]           w_grant;
    logic                 w_busy;
    logic [15:0]          w_xfer;
    logic [15:0]          w_beats;
    logic                 wrap_done = 1'b0;

    logic [7:0]           sent  [NM];
    int                   limit [NM] = '{default: 0};
    logic [7:0]           base  [NM] = '{8'h10, 8'h40, 8'hA5, 8'h30};

    logic [NM+DW-1:0]     sb_q [$];
    int                   n_cmp = 0;
    int                   n_err = 0;
    int                   n_beat = 0;

    always #5 sys_clk = ~sys_clk;

    handshake_arbiter #(
        .NUM_MASTERS (NM),
        .DATA_WIDTH  (DW),
        .MAX_BURST   (MB)
    ) u_dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .m_vaild    (m_vaild),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .s_vaild    (s_vaild),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .grant      (grant),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    handshake_arbiter #(
        .NUM_MASTERS (2),
        .DATA_WIDTH  (8),
        .MAX_BURST   (16)
    ) u_wrap (
        .sys_clk    (sys_clk),
        .reset_n    (w_rst_n),
        .m_vaild    (2'b11),
        .m_data     (16'hB1A0),
        .m_ready    (w_m_ready),
        .s_vaild    (w_s_vaild),
        .s_data     (w_s_data),
        .s_ready    (1'b1),
        .grant      (w_grant),
        .busy       (w_busy),
        .xfer_count (w_xfer)
    );

    // ---------------- master source models ----------------
    always_comb begin
        m_vaild = '0;
        m_data  = '0;
        for (int i = 0; i < NM; i++) begin
            m_vaild[i]         = (int'(sent[i]) < limit[i]);
            m_data[i*DW +: DW] = base[i] + sent[i];
        end
    end

    always @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NM; i++) sent[i] <= 8'd0;
        end else begin
            for (int i = 0; i < NM; i++) begin
                if (m_vaild[i] && m_ready[i]) sent[i] <= sent[i] + 8'd1;
            end
        end
    end

    always @(posedge sys_clk or negedge w_rst_n) begin
        if (!w_rst_n) w_beats <= 16'd0;
        else if (w_s_vaild) w_beats <= w_beats + 16'd1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NM-1:0] oh(input int m);
        return NM'(1) << m;
    endfunction

    task automatic push_beats(input int m, input int first, input int n);
        for (int k = 0; k < n; k++) begin
            sb_q.push_back({oh(m), 8'(int'(base[m]) + first + k)});
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        for (int i = 0; i < NM; i++) limit[i] = 0;
        s_ready = 1'b0;
        reset_n = 1'b0;
        ticks(2);
        reset_n = 1'b1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge sys_clk) begin
        if (reset_n && s_vaild && s_ready) begin
            n_beat++;
            $display("beat %0d: grant=%b data=0x%02h m_ready=%b", n_beat, grant, s_data, m_ready);
            if (sb_q.size() == 0) begin
                check("sb_extra_beat", 32'(s_data), 32'hFFFF_FFFF);
            end else begin
                check("beat", 32'({grant, s_data}), 32'(sb_q.pop_front()));
            end
        end
    end

    // ---------------- counter wrap on the background instance ----------------
    initial begin
        int c;
        w_rst_n = 1'b0;
        ticks(2);
        w_rst_n = 1'b1;
        c = 0;
        while (w_beats != 16'hFFFF && c < 75000) begin
            @(negedge sys_clk);
            c++;
        end
        check("wrap_reach_ffff", 32'(w_beats), 32'h0000_FFFF);
        check("wrap_xfer_ffff", 32'(w_xfer), 32'h0000_FFFF);
        c = 0;
        while (w_beats != 16'h0000 && c < 40) begin
            @(negedge sys_clk);
            c++;
        end
        check("wrap_xfer_zero", 32'(w_xfer), 32'h0);
        check("wrap_grant_le1", 32'($countones(w_grant) <= 1), 32'h1);
        check("wrap_busy_vs_grant", 32'(w_busy), 32'(|w_grant));
        c = 0;
        while (w_beats != 16'h0001 && c < 40) begin
            @(negedge sys_clk);
            c++;
        end
        // 65536 beats are exactly 4096 full bursts, so the next burst is master 0's
        check("wrap_xfer_one", 32'(w_xfer), 32'h1);
        check("wrap_grant_after", 32'(w_grant), 32'h1);
        check("wrap_data_after", 32'(w_s_data), 32'hA0);
        wrap_done = 1'b1;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [5:0] pat;
        int         c;
        pat = 6'b111001;
        reset_n = 1'b0;
        s_ready = 1'b0;
        ticks(2);

        // reset state
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_s_vaild", 32'(s_vaild), 32'h0);
        check("rst_m_ready", 32'(m_ready), 32'h0);
        check("rst_s_data", 32'(s_data), 32'h0);
        check("rst_xfer", 32'(xfer_count), 32'h0);
        reset_n = 1'b1;

        // single master 2, two bursts
        s_ready  = 1'b1;
        limit[2] = 8;
        push_beats(2, 0, 8);
        tick();
        check("t1_grant", 32'(grant), 32'h4);
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_s_data", 32'(s_data), 32'hA5);
        ticks(3);
        check("t1_hold", 32'(grant), 32'h4);
        check("t1_xfer3", 32'(xfer_count), 32'd3);
        tick();
        check("t1_idle_grant", 32'(grant), 32'h0);
        check("t1_idle_busy", 32'(busy), 32'h0);
        check("t1_xfer4", 32'(xfer_count), 32'd4);
        tick();
        check("t1_regrant", 32'(grant), 32'h4);
        ticks(4);
        check("t1_end_grant", 32'(grant), 32'h0);
        check("t1_xfer8", 32'(xfer_count), 32'd8);
        tick();
        check("t1_stay_idle", 32'(busy), 32'h0);

        // all four masters continuously, two rounds
        do_reset();
        s_ready = 1'b1;
        for (int i = 0; i < NM; i++) limit[i] = 8;
        for (int r = 0; r < 2; r++)
            for (int m = 0; m < NM; m++) push_beats(m, r * 4, 4);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t2_grant", 32'(grant), 32'(oh(k % NM)));
            ticks(4);
            check("t2_gap", 32'(busy), 32'h0);
        end
        check("t2_xfer", 32'(xfer_count), 32'd32);

        // slave ready toggling under master 1
        do_reset();
        limit[1] = 4;
        push_beats(1, 0, 4);
        tick();
        check("t3_grant", 32'(grant), 32'h2);
        for (int j = 0; j < 6; j++) begin
            s_ready = pat[j];
            #1;
            check("t3_m_ready", 32'(m_ready), pat[j] ? 32'h2 : 32'h0);
            tick();
        end
        check("t3_end_grant", 32'(grant), 32'h0);
        check("t3_xfer", 32'(xfer_count), 32'd4);

        // early release by master 3 while master 0 waits
        do_reset();
        s_ready  = 1'b1;
        limit[3] = 2;
        push_beats(3, 0, 2);
        push_beats(0, 0, 4);
        tick();
        check("t4_grant3", 32'(grant), 32'h8);
        limit[0] = 4;
        ticks(2);
        check("t4_owner_held", 32'(grant), 32'h8);
        check("t4_s_vaild_low", 32'(s_vaild), 32'h0);
        check("t4_m_ready0", 32'(m_ready), 32'h8);
        tick();
        check("t4_idle", 32'(busy), 32'h0);
        tick();
        check("t4_grant0", 32'(grant), 32'h1);
        ticks(4);
        check("t4_end", 32'(grant), 32'h0);
        check("t4_xfer", 32'(xfer_count), 32'd6);

        // reset in the middle of master 1's second burst
        do_reset();
        s_ready  = 1'b1;
        limit[1] = 8;
        push_beats(1, 0, 6);
        tick();
        check("t5_grant1", 32'(grant), 32'h2);
        ticks(5);
        check("t5_regrant1", 32'(grant), 32'h2);
        ticks(2);
        check("t5_busy_mid", 32'(busy), 32'h1);
        limit[1] = 0;
        reset_n  = 1'b0;
        #1;
        check("t5_rst_s_vaild", 32'(s_vaild), 32'h0);
        check("t5_rst_m_ready", 32'(m_ready), 32'h0);
        check("t5_rst_grant", 32'(grant), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_xfer", 32'(xfer_count), 32'h0);
        tick();
        limit[1] = 4;
        limit[3] = 4;
        push_beats(1, 0, 4);
        push_beats(3, 0, 4);
        reset_n = 1'b1;
        tick();
        check("t5_restart_grant", 32'(grant), 32'h2);
        ticks(4);
        check("t5_gap", 32'(grant), 32'h0);
        tick();
        check("t5_next_grant", 32'(grant), 32'h8);
        ticks(4);
        check("t5_end", 32'(grant), 32'h0);
        check("t5_xfer", 32'(xfer_count), 32'd8);

        check("sb_drained", 32'(sb_q.size()), 32'h0);

        c = 0;
        while (!wrap_done && c < 80000) begin
            @(posedge sys_clk);
            c++;
        end
        check("wrap_done", 32'(wrap_done), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
